// File: rtl/fourth_step_pkg.sv
// ==========================================================================
// fourth_step_pkg: shared widths, control bundle and fault helper for MEM.
// Revision: 1.0
// ==========================================================================
`default_nettype none

package fourth_step_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_REG_ADDR_WIDTH = 5;
  localparam int DEF_MEM_ADDR_WIDTH = 8;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Only memory instructions can fault; ALU ops may carry any low address bits.
  function automatic logic is_misaligned(input logic [1:0] byte_off,
                                         input logic       rd,
                                         input logic       wr);
    return (rd | wr) && (byte_off != 2'b00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fourth_step_data_memory.sv
// ==========================================================================
// data_memory: single-port word RAM, synchronous read-first, gated by en.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module data_memory
  import fourth_step_pkg::*;
#(
  parameter int WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (reset && en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= re ? mem[addr] : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fourth_step.sv
// ==========================================================================
// fourth_step: MEM stage -- EX/MEM latch, branch resolve, data memory, MEM/WB.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module fourth_step
  import fourth_step_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      branch,
  input  logic                      memRead,
  input  logic                      memWrite,
  input  logic                      regWrite,
  input  logic                      memToReg,
  input  logic [DATA_WIDTH-1:0]     addResult,
  input  logic                      zero,
  input  logic [DATA_WIDTH-1:0]     aluResult,
  input  logic [DATA_WIDTH-1:0]     reg2Out,
  input  logic [REG_ADDR_WIDTH-1:0] muxRegDstOut,
  output logic                      pcSrc,
  output logic [DATA_WIDTH-1:0]     branchTarget,
  output logic                      wbRegWrite,
  output logic                      wbMemToReg,
  output logic [DATA_WIDTH-1:0]     wbReadData,
  output logic [DATA_WIDTH-1:0]     wbAluResult,
  output logic [REG_ADDR_WIDTH-1:0] wbRegDst,
  output logic                      memFault
);

  ctrl_t                     ex_ctrl;
  ctrl_t                     exm_ctrl;
  logic [DATA_WIDTH-1:0]     exm_add_result;
  logic                      exm_zero;
  logic [DATA_WIDTH-1:0]     exm_alu_result;
  logic [DATA_WIDTH-1:0]     exm_reg2;
  logic [REG_ADDR_WIDTH-1:0] exm_reg_dst;

  logic misaligned;
  logic mem_en;
  logic mem_we;
  logic mem_re;

  assign ex_ctrl = '{branch:     branch,
                     mem_read:   memRead,
                     mem_write:  memWrite,
                     reg_write:  regWrite,
                     mem_to_reg: memToReg};

  // A flush must land its bubble even while the stage is stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exm_ctrl       <= CTRL_BUBBLE;
      exm_add_result <= '0;
      exm_zero       <= 1'b0;
      exm_alu_result <= '0;
      exm_reg2       <= '0;
      exm_reg_dst    <= '0;
    end else if (flush || !stall) begin
      exm_ctrl       <= flush ? CTRL_BUBBLE : ex_ctrl;
      exm_add_result <= addResult;
      exm_zero       <= zero;
      exm_alu_result <= aluResult;
      exm_reg2       <= reg2Out;
      exm_reg_dst    <= muxRegDstOut;
    end
  end

  assign pcSrc        = exm_ctrl.branch & exm_zero;
  assign branchTarget = exm_add_result;

  assign misaligned = is_misaligned(exm_alu_result[1:0], exm_ctrl.mem_read,
                                    exm_ctrl.mem_write);
  assign mem_en     = ~stall;
  assign mem_we     = exm_ctrl.mem_write & ~misaligned;
  assign mem_re     = exm_ctrl.mem_read & ~misaligned;

  // The RAM output register doubles as the MEM/WB read-data field.
  data_memory #(
    .WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_data_memory (
    .clk   (clk),
    .reset (reset),
    .en    (mem_en),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (exm_alu_result[MEM_ADDR_WIDTH+1:2]),
    .wdata (exm_reg2),
    .rdata (wbReadData)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      wbRegWrite  <= 1'b0;
      wbMemToReg  <= 1'b0;
      wbAluResult <= '0;
      wbRegDst    <= '0;
      memFault    <= 1'b0;
    end else if (!stall) begin
      wbRegWrite  <= exm_ctrl.reg_write & ~misaligned;
      wbMemToReg  <= exm_ctrl.mem_to_reg;
      wbAluResult <= exm_alu_result;
      wbRegDst    <= exm_reg_dst;
      memFault    <= misaligned;
    end
  end

endmodule

`default_nettype wire
